// File: rtl/mac_fp_minifloat_vec_pkg.sv
// Shared widths, E2M1 defaults, operand decode and sign conversion for the minifloat MAC.
// Latency: none (constants and combinational functions only).
// Backpressure: not applicable.
package mac_fp_pkg;

  localparam int E2M1_EXP_WIDTH = 2;
  localparam int E2M1_MAN_WIDTH = 1;
  localparam int DEF_LANES      = 4;
  localparam int DEF_ACC_WIDTH  = 23;

  // Decoded operand: significand with hidden bit applied, and effective exponent.
  typedef struct packed {
    logic [15:0] frac;
    logic [15:0] e;
  } dec_t;

  function automatic int fp_bias(input int exp_w);
    return 2 ** (exp_w - 1) - 1;
  endfunction

  // Width of the largest lane magnitude, (max frac)^2 shifted by (2*max_exp - 2).
  function automatic int prod_w(input int exp_w, input int man_w);
    return 2 * (man_w + 1) + 2 * (2 ** exp_w - 1) - 2;
  endfunction

  // Exact signed width of the sum of all lanes in one beat.
  function automatic int lsum_w(input int exp_w, input int man_w, input int lanes);
    return prod_w(exp_w, man_w) + 1 + $clog2(lanes);
  endfunction

  // Zero exponent is subnormal: no hidden bit, but it sits at the same scale as exp=1.
  function automatic dec_t fp_decode(input logic [15:0] exp_f, input logic [15:0] man_f,
                                     input int man_w);
    dec_t d;
    if (exp_f == 16'd0) begin
      d.frac = man_f;
      d.e    = 16'd1;
    end else begin
      d.frac = man_f | (16'd1 << man_w);
      d.e    = exp_f;
    end
    return d;
  endfunction

  // Negating a zero magnitude wraps back to zero, so -0 never produces a nonzero pattern.
  function automatic logic [31:0] signMagnitude_to_2sComplement(input logic sign,
                                                                input logic [31:0] mag);
    return sign ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/mac_fp_minifloat_vec_if.sv
// Operand-beat and group-result streams of the minifloat dot-product MAC.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready handshakes; slave side is the MAC.
interface mac_fp_minifloat_vec_if import mac_fp_pkg::*; #(
  parameter int EXP_WIDTH = E2M1_EXP_WIDTH,
  parameter int MAN_WIDTH = E2M1_MAN_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
);
  localparam int OPW = 1 + EXP_WIDTH + MAN_WIDTH;

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [LANES*OPW-1:0]   weight;
  logic [LANES*OPW-1:0]   act;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out;
  logic                   ovf;

  modport master (
    output in_valid, in_last, weight, act, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, in_last, weight, act, out_ready,
    output in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/mac_fp_minifloat_vec_lane.sv
// One lane: decode weight and activation, multiply significands, align, convert to signed.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module mac_fp_lane import mac_fp_pkg::*; #(
  parameter int EXP_WIDTH = E2M1_EXP_WIDTH,
  parameter int MAN_WIDTH = E2M1_MAN_WIDTH
) (
  input  logic [EXP_WIDTH+MAN_WIDTH:0]                     w_i,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]                     a_i,
  output logic signed [prod_w(EXP_WIDTH, MAN_WIDTH):0]     val_o
);
  localparam int OPW    = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int PROD_W = prod_w(EXP_WIDTH, MAN_WIDTH);

  dec_t        dw;
  dec_t        da;
  logic [15:0] sh;
  logic [31:0] mag;

  assign dw = fp_decode(16'(w_i[MAN_WIDTH+EXP_WIDTH-1:MAN_WIDTH]), 16'(w_i[MAN_WIDTH-1:0]),
                        MAN_WIDTH);
  assign da = fp_decode(16'(a_i[MAN_WIDTH+EXP_WIDTH-1:MAN_WIDTH]), 16'(a_i[MAN_WIDTH-1:0]),
                        MAN_WIDTH);

  // Effective exponents are >= 1, so the smallest product lands on the unit LSB.
  assign sh  = dw.e + da.e - 16'd2;
  assign mag = (32'(dw.frac) * 32'(da.frac)) << sh;

  assign val_o = (PROD_W + 1)'(signMagnitude_to_2sComplement(w_i[OPW-1] ^ a_i[OPW-1], mag));
endmodule

// File: rtl/mac_fp_minifloat_vec.sv
// LANES-wide minifloat dot-product MAC; beats accumulate until a 'last' beat emits the group sum.
// Latency: last beat accepted at edge t -> out_valid after edge t+3; back-to-back groups allowed.
// Backpressure: whole pipeline freezes while out_valid & ~out_ready; in_ready = ~stall. MAC_FP_SAT_EN selects saturating accumulation with ovf.
module mac_fp_minifloat_vec import mac_fp_pkg::*; #(
  parameter int EXP_WIDTH = E2M1_EXP_WIDTH,
  parameter int MAN_WIDTH = E2M1_MAN_WIDTH,
  parameter int LANES     = DEF_LANES,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  mac_fp_minifloat_vec_if.slave  bus
);
  localparam int OPW    = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int LV     = prod_w(EXP_WIDTH, MAN_WIDTH) + 1;
  localparam int LSUM_W = lsum_w(EXP_WIDTH, MAN_WIDTH, LANES);

  logic                        adv;
  logic                        s1_vld_q, s1_last_q;
  logic [LANES*OPW-1:0]        s1_w_q, s1_a_q;
  logic signed [LV-1:0]        lane_val [LANES];
  logic signed [LV-1:0]        prd_q [LANES];
  logic                        prd_vld_q, prd_last_q;
  logic signed [LSUM_W-1:0]    sum_d, sum_q;
  logic                        sum_vld_q, sum_last_q;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q, out_q;
  logic                        out_vld_q;

  // One result register downstream, so any unaccepted result stalls every stage.
  assign adv          = ~(out_vld_q & ~bus.out_ready);
  assign bus.in_ready = adv;
  assign bus.out_valid = out_vld_q;
  assign bus.out       = out_q;

  // S1: capture the accepted beat; bubbles keep the previous operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_w_q    <= '0;
      s1_a_q    <= '0;
    end else if (adv) begin
      s1_vld_q  <= bus.in_valid;
      s1_last_q <= bus.in_valid & bus.in_last;
      if (bus.in_valid) begin
        s1_w_q <= bus.weight;
        s1_a_q <= bus.act;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_fp_lane #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_lane (
      .w_i   (s1_w_q[g*OPW +: OPW]),
      .a_i   (s1_a_q[g*OPW +: OPW]),
      .val_o (lane_val[g])
    );
  end

  // S2a: register the signed per-lane products.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) prd_q[i] <= '0;
      prd_vld_q  <= 1'b0;
      prd_last_q <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < LANES; i++) prd_q[i] <= lane_val[i];
      prd_vld_q  <= s1_vld_q;
      prd_last_q <= s1_last_q;
    end
  end

  // Exact lane reduction; the sum width leaves room for every lane at full scale.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) sum_d = sum_d + LSUM_W'(prd_q[i]);
  end

  // S2b: register the beat sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q      <= '0;
      sum_vld_q  <= 1'b0;
      sum_last_q <= 1'b0;
    end else if (adv) begin
      sum_q      <= sum_d;
      sum_vld_q  <= prd_vld_q;
      sum_last_q <= prd_last_q;
    end
  end

`ifdef MAC_FP_SAT_EN
  localparam int SUM_W = ((ACC_WIDTH > LSUM_W) ? ACC_WIDTH : LSUM_W) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (ACC_WIDTH - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

  logic signed [SUM_W-1:0] add_wide;
  logic                    sat_hi, sat_lo, sat_hit;
  logic                    sticky_q, ovf_q;

  // Add at a width where neither operand can overflow, then clamp to the accumulator range.
  always_comb begin
    add_wide = SUM_W'(acc_q) + SUM_W'(sum_q);
    sat_hi   = add_wide > SAT_MAX;
    sat_lo   = add_wide < SAT_MIN;
    sat_hit  = sat_hi | sat_lo;
    if (sat_hi)      acc_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else if (sat_lo) acc_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else             acc_d = add_wide[ACC_WIDTH-1:0];
  end

  // Sticky saturation flag for the open group; published with the group result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (adv && sum_vld_q) begin
      if (sum_last_q) begin
        ovf_q    <= sticky_q | sat_hit;
        sticky_q <= 1'b0;
      end else begin
        sticky_q <= sticky_q | sat_hit;
      end
    end
  end

  assign bus.ovf = ovf_q;
`else
  // Modular accumulation: truncating the sign-extended beat sum is exact mod 2**ACC_WIDTH.
  always_comb begin
    acc_d = acc_q + ACC_WIDTH'(sum_q);
  end

  assign bus.ovf = 1'b0;
`endif

  // S3: accumulate, or close the group into the held result register and restart clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (adv) begin
      if (sum_vld_q && sum_last_q) begin
        out_q     <= acc_d;
        out_vld_q <= 1'b1;
        acc_q     <= '0;
      end else begin
        out_vld_q <= 1'b0;
        if (sum_vld_q) acc_q <= acc_d;
      end
    end
  end
endmodule
